lfsr_rx_checker: RTL and testbench
==================================

Name: lfsr_rx_checker

Overview:
- Receive-side counterpart to the SFP0 LFSR pattern generator in gth_driver.
- Consumes 32-bit parallel words from the GTH RX user-clock domain and self-synchronises to the PRBS31 stream (x^31 + x^28 + 1).
- Reports lock state, word and error counts, and a 4-bit status vector to the system block, for link bring-up without the classical NIC.

Parameters:
- DATA_W, 32, RX word width. Only 32 is supported; elaborate-time error otherwise.
- LOCK_WORDS, 64, consecutive matching words required to declare lock.
- UNLOCK_ERRS, 8, consecutive erroneous words in LOCKED that force a return to SEARCH.
- CNT_W, 32, width of the statistic counters.

Ports:
- clk, in, 1: GTH RX user clock. Only clock.
- resetn, in, 1: Asynchronous active-low reset.
- rx_data, in, DATA_W: Received word. Bit 0 is earliest in time.
- rx_valid, in, 1: rx_data qualifier. No backpressure.
- clear, in, 1: Synchronous clear of counters and sticky flags.
- locked, out, 1: Checker is in LOCKED.
- err_pulse, out, 1: One-cycle pulse per erroneous word while locked.
- word_cnt, out, CNT_W: Words checked while locked. Saturating.
- err_word_cnt, out, CNT_W: Erroneous words while locked. Saturating.
- status, out, 4: {lost_lock_sticky, err_seen_sticky, locked, valid_seen_sticky}.

Behaviour:
- Reset: all outputs 0; state SEARCH; internal LFSR state 0; good/bad run counters 0.
- Next-word function: nxt(w) gives the 32 bits following the 31-bit history held in w[31:1], bit-serial order from bit 0. Pure combinational.
- Checking happens only on cycles with rx_valid=1. Idle cycles hold all state.
- SEARCH:
  - Valid word w != 0: exp <= nxt(w), good_cnt <= 0, go to VERIFY.
  - w == 0 (degenerate LFSR state): rejected; stay in SEARCH.
- VERIFY:
  - rx_data == exp: good_cnt++, exp <= nxt(exp).
  - good_cnt reaching LOCK_WORDS-1 on a match: go to LOCKED next cycle.
  - Any mismatch: go to SEARCH. The mismatching word is not used as a seed.
- LOCKED:
  - exp is always advanced from the internal LFSR state (exp <= nxt(exp)), never from rx_data, so a single bit flip counts as exactly one erroneous word.
  - Match: bad_cnt <= 0.
  - Mismatch: bad_cnt++. Reaching UNLOCK_ERRS: go to SEARCH and set lost_lock_sticky.
- Latency: for a word accepted in cycle N, err_pulse, word_cnt and err_word_cnt update in cycle N+1; locked rises in cycle N+1 after the LOCK_WORDS-th match.
- Counters:
  - Count only in LOCKED, including the word that triggers the unlock.
  - Saturate at all-ones with no wrap.
- clear:
  - Zeroes word_cnt, err_word_cnt and the three sticky flags in the next cycle; lock state is unaffected.
  - If clear coincides with a counted word, clear wins and the counter reads 0.
- valid_seen_sticky: set on the first rx_valid after reset or clear.
- Mid-stream resetn assertion: immediate return to reset values, independent of clk.

Optional Feature:
- Macro: LFSR_RX_CHECKER_BITERR_EN.
- Defined:
  - Adds output bit_err_cnt [CNT_W-1:0] = saturating sum of popcount(rx_data ^ exp) over locked words.
  - Popcount is registered, so bit_err_cnt updates in cycle N+2. Cleared by clear and resetn like the other counters.
- Undefined: no port, no popcount logic. All other behaviour is identical.

Decomposition:
- Package lfsr_rx_checker_pkg:
  - State enum {SEARCH, VERIFY, LOCKED}.
  - PRBS31 tap constants (31, 28).
  - Status bit index constants.
- Sub-module lfsr_rx_checker_nxt: combinational 32-bit PRBS31 next-word function. Shared with any future TX-side model.

Test Plan:
- Clean PRBS31 from seed 0x7FFFFFFF, rx_valid=1 continuously -> locked=1 at cycle 66 after the first word; err_pulse never asserts; word_cnt increments once per word after lock.
- Locked stream with one bit flipped in one word -> one err_pulse; err_word_cnt=1; bad_cnt recovers; locked stays 1. With LFSR_RX_CHECKER_BITERR_EN: bit_err_cnt=1.
- 8 consecutive corrupted words (bit 5 inverted) while locked -> locked=0 after the 8th word; status[3]=1; err_word_cnt=8; relock after 1+64 clean words.
- All-zero words for 100 cycles, then a valid PRBS stream -> stays in SEARCH throughout the zeros; then locks normally.
- rx_valid toggled 1/0 every cycle on a clean stream -> lock after 64 valid words; gaps cause no errors.
- clear asserted in the same cycle as a counted word with err_word_cnt=3 -> both counters 0 next cycle; stickies 0; locked unchanged. resetn pulsed mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/lfsr_rx_checker_pkg.sv
// Shared definitions for the PRBS31 receive checker: FSM states,
// polynomial taps and status vector bit positions.
package lfsr_rx_checker_pkg;

    // Checker lock states
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // PRBS31 polynomial x^31 + x^28 + 1: each new bit is the XOR of the
    // bits 31 and 28 positions earlier in the serial stream.
    localparam int PRBS_TAP_A = 31;
    localparam int PRBS_TAP_B = 28;

    // Only word width supported by the next-word function
    localparam int WORD_W = 32;

    // Bit positions inside the status vector
    localparam int ST_VALID_SEEN = 0;
    localparam int ST_LOCKED     = 1;
    localparam int ST_ERR_SEEN   = 2;
    localparam int ST_LOST_LOCK  = 3;

endpackage

// File: rtl/lfsr_rx_checker_nxt.sv
// Combinational PRBS31 next-word function. Given the 31 most recent
// stream bits (oldest in bit 0), returns the following 32 bits with the
// earliest bit in bit 0. Usable by a TX-side model as well.
module lfsr_rx_checker_nxt
    import lfsr_rx_checker_pkg::*;
(
    input  logic [30:0] hist,
    output logic [31:0] word
);

    // Unroll the serial recurrence 32 steps beyond the history
    always_comb begin
        logic [62:0] s;
        s = '0;
        s[30:0] = hist;
        for (int k = 31; k < 63; k++) begin
            s[k] = s[k - PRBS_TAP_A] ^ s[k - PRBS_TAP_B];
        end
        word = s[62:31];
    end

endmodule

// File: rtl/lfsr_rx_checker.sv
// PRBS31 receive checker for GTH link bring-up. Self-synchronises to the
// incoming stream, then counts checked and erroneous words.
// Optional feature macro: LFSR_RX_CHECKER_BITERR_EN adds bit_err_cnt,
// a saturating count of errored bits over locked words (two-cycle latency).
// Valid/ready note: rx_valid qualifies rx_data for one cycle; there is no
// ready, the checker accepts every valid word.
module lfsr_rx_checker
    import lfsr_rx_checker_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int LOCK_WORDS  = 64,
    parameter int UNLOCK_ERRS = 8,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    input  logic              clear,
    output logic              locked,
    output logic              err_pulse,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  err_word_cnt,
    output logic [3:0]        status,
`ifdef LFSR_RX_CHECKER_BITERR_EN
    output logic [CNT_W-1:0]  bit_err_cnt,
`endif
    output state_e            dbg_state
);

    localparam int GOOD_W = $clog2(LOCK_WORDS + 1);
    localparam int BAD_W  = $clog2(UNLOCK_ERRS + 1);

    if (DATA_W != WORD_W) begin : g_bad_width
        $error("lfsr_rx_checker supports DATA_W = 32 only");
    end

    state_e             state;
    state_e             state_nxt;
    logic [DATA_W-1:0]  exp_word;
    logic [DATA_W-1:0]  nxt_word;
    logic [30:0]        nxt_hist;
    logic [GOOD_W-1:0]  good_cnt;
    logic [BAD_W-1:0]   bad_cnt;
    logic               match;
    logic               take_word;
    logic               is_err;
    logic               lose_lock;
    logic               lost_sticky;
    logic               err_sticky;
    logic               valid_sticky;

    // While searching, the received word seeds the predictor; afterwards the
    // internal prediction advances itself so bit flips never propagate.
    assign nxt_hist = (state == SEARCH) ? rx_data[31:1] : exp_word[31:1];

    lfsr_rx_checker_nxt u_nxt (
        .hist (nxt_hist),
        .word (nxt_word)
    );

    assign match = (rx_data == exp_word);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-word event flags
    always_comb begin
        state_nxt = state;
        take_word = 1'b0;
        is_err    = 1'b0;
        lose_lock = 1'b0;
        if (rx_valid) begin
            case (state)
                SEARCH: begin
                    if (rx_data != '0) state_nxt = VERIFY;
                end
                VERIFY: begin
                    if (!match) begin
                        state_nxt = SEARCH;
                    end else if (good_cnt == GOOD_W'(LOCK_WORDS - 1)) begin
                        state_nxt = LOCKED;
                    end
                end
                LOCKED: begin
                    take_word = 1'b1;
                    if (!match) begin
                        is_err = 1'b1;
                        if (bad_cnt == BAD_W'(UNLOCK_ERRS - 1)) begin
                            lose_lock = 1'b1;
                            state_nxt = SEARCH;
                        end
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    // Prediction register and good/bad run counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            exp_word <= '0;
            good_cnt <= '0;
            bad_cnt  <= '0;
        end else if (rx_valid) begin
            case (state)
                SEARCH: begin
                    if (rx_data != '0) begin
                        exp_word <= nxt_word;
                        good_cnt <= '0;
                    end
                end
                VERIFY: begin
                    if (match) begin
                        exp_word <= nxt_word;
                        good_cnt <= good_cnt + GOOD_W'(1);
                        bad_cnt  <= '0;
                    end
                end
                LOCKED: begin
                    exp_word <= nxt_word;
                    bad_cnt  <= match ? '0 : bad_cnt + BAD_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Statistics counters and sticky flags; clear takes priority
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_pulse    <= 1'b0;
            word_cnt     <= '0;
            err_word_cnt <= '0;
            lost_sticky  <= 1'b0;
            err_sticky   <= 1'b0;
            valid_sticky <= 1'b0;
        end else begin
            err_pulse <= is_err;
            if (clear) begin
                word_cnt     <= '0;
                err_word_cnt <= '0;
                lost_sticky  <= 1'b0;
                err_sticky   <= 1'b0;
                valid_sticky <= 1'b0;
            end else begin
                if (take_word && word_cnt != '1) word_cnt <= word_cnt + CNT_W'(1);
                if (is_err && err_word_cnt != '1) err_word_cnt <= err_word_cnt + CNT_W'(1);
                if (is_err)    err_sticky   <= 1'b1;
                if (lose_lock) lost_sticky  <= 1'b1;
                if (rx_valid)  valid_sticky <= 1'b1;
            end
        end
    end

`ifdef LFSR_RX_CHECKER_BITERR_EN
    logic [5:0]     pop_q;
    logic [CNT_W:0] bit_sum;

    assign bit_sum = {1'b0, bit_err_cnt} + (CNT_W + 1)'(pop_q);

    // Registered popcount of the error pattern, then saturating accumulate
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pop_q       <= '0;
            bit_err_cnt <= '0;
        end else if (clear) begin
            pop_q       <= '0;
            bit_err_cnt <= '0;
        end else begin
            pop_q       <= take_word ? 6'($countones(rx_data ^ exp_word)) : 6'd0;
            bit_err_cnt <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
        end
    end
`endif

    assign locked    = (state == LOCKED);
    assign dbg_state = state;

    assign status[ST_VALID_SEEN] = valid_sticky;
    assign status[ST_LOCKED]     = locked;
    assign status[ST_ERR_SEEN]   = err_sticky;
    assign status[ST_LOST_LOCK]  = lost_sticky;

endmodule

// File: tb/tb_lfsr_rx_checker.sv
// Bench for lfsr_rx_checker: directed phases plus random traffic, checked
// by a scoreboard against a bit-serial PRBS31 reference model.
module tb_lfsr_rx_checker;
    import lfsr_rx_checker_pkg::*;

    localparam int LOCK_WORDS  = 64;
    localparam int UNLOCK_ERRS = 8;
    localparam int M_SEARCH = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic        clk;
    logic        resetn;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [31:0] word_cnt;
    logic [31:0] err_word_cnt;
    logic [3:0]  status;
    state_e      dbg_state;
`ifdef LFSR_RX_CHECKER_BITERR_EN
    logic [31:0] bit_err_cnt;
`endif

    lfsr_rx_checker #(
        .DATA_W(32), .LOCK_WORDS(LOCK_WORDS), .UNLOCK_ERRS(UNLOCK_ERRS), .CNT_W(32)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .clear        (clear),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .word_cnt     (word_cnt),
        .err_word_cnt (err_word_cnt),
        .status       (status),
`ifdef LFSR_RX_CHECKER_BITERR_EN
        .bit_err_cnt  (bit_err_cnt),
`endif
        .dbg_state    (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic        locked;
        logic        err_pulse;
        logic [31:0] word_cnt;
        logic [31:0] err_cnt;
        logic [31:0] bit_cnt;
        logic [3:0]  status;
        logic        in_search;
    } exp_t;

    exp_t exp_q[$];
    exp_t pend;
    bit   have_pend;
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Serial definition of PRBS31: s[n] = s[n-31] ^ s[n-28]. The word's bits
    // 31..1 are the last 31 stream bits; produce the next 32.
    function automatic logic [31:0] ref_next(input logic [31:0] w);
        bit          s[$];
        logic [31:0] r;
        for (int i = 1; i < 32; i++) s.push_back(w[i]);
        while (s.size() < 63) s.push_back(s[s.size() - 31] ^ s[s.size() - 28]);
        for (int j = 0; j < 32; j++) r[j] = s[31 + j];
        return r;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input int unsigned b);
        longint unsigned s;
        s = longint'(a) + longint'(b);
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    int          m_mode;
    logic [31:0] m_exp;
    int          m_good;
    int          m_bad;
    logic [31:0] m_words;
    logic [31:0] m_errs;
    logic [31:0] m_bits;
    int          m_pop_prev;
    bit          m_valid_seen;
    bit          m_err_seen;
    bit          m_lost;

    task automatic model_reset();
        m_mode = M_SEARCH; m_exp = '0; m_good = 0; m_bad = 0;
        m_words = '0; m_errs = '0; m_bits = '0; m_pop_prev = 0;
        m_valid_seen = 0; m_err_seen = 0; m_lost = 0;
    endtask

    // Apply one input cycle to the model; returns outputs seen after the edge
    task automatic model_step(input logic [31:0] d, input logic v, input logic c, output exp_t e);
        int pop_now;
        bit errp;
        pop_now = 0;
        errp = 0;
        if (v) begin
            m_valid_seen = 1;
            case (m_mode)
                M_SEARCH: begin
                    if (d != 0) begin
                        m_exp = ref_next(d);
                        m_good = 0;
                        m_mode = M_VERIFY;
                    end
                end
                M_VERIFY: begin
                    if (d == m_exp) begin
                        m_good++;
                        m_exp = ref_next(m_exp);
                        if (m_good == LOCK_WORDS) begin
                            m_mode = M_LOCKED;
                            m_bad = 0;
                        end
                    end else begin
                        m_mode = M_SEARCH;
                    end
                end
                default: begin
                    m_words = sat_add(m_words, 1);
                    pop_now = $countones(d ^ m_exp);
                    if (d != m_exp) begin
                        errp = 1;
                        m_errs = sat_add(m_errs, 1);
                        m_err_seen = 1;
                        m_bad++;
                        if (m_bad == UNLOCK_ERRS) begin
                            m_mode = M_SEARCH;
                            m_lost = 1;
                        end
                    end else begin
                        m_bad = 0;
                    end
                    m_exp = ref_next(m_exp);
                end
            endcase
        end
        m_bits = sat_add(m_bits, m_pop_prev);
        m_pop_prev = pop_now;
        if (c) begin
            m_words = '0; m_errs = '0; m_bits = '0; m_pop_prev = 0;
            m_valid_seen = 0; m_err_seen = 0; m_lost = 0;
        end
        e.locked    = (m_mode == M_LOCKED);
        e.err_pulse = errp;
        e.word_cnt  = m_words;
        e.err_cnt   = m_errs;
        e.bit_cnt   = m_bits;
        e.status    = {m_lost, m_err_seen, (m_mode == M_LOCKED), m_valid_seen};
        e.in_search = (m_mode == M_SEARCH);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("locked", 32'(locked), 32'(e.locked));
            check("err_pulse", 32'(err_pulse), 32'(e.err_pulse));
            check("word_cnt", word_cnt, e.word_cnt);
            check("err_word_cnt", err_word_cnt, e.err_cnt);
            check("status", 32'(status), 32'(e.status));
            check("in_search", 32'(dbg_state == SEARCH), 32'(e.in_search));
`ifdef LFSR_RX_CHECKER_BITERR_EN
            check("bit_err_cnt", bit_err_cnt, e.bit_cnt);
`endif
        end
    end

    // ---------------- driver tasks ----------------
    logic [31:0] gen_w;

    task automatic cyc(input logic [31:0] d, input logic v, input logic c);
        @(posedge clk);
        if (have_pend) exp_q.push_back(pend);
        #1;
        rx_data  = d;
        rx_valid = v;
        clear    = c;
        model_step(d, v, c, pend);
        have_pend = 1;
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(gen_w, 1'b1, 1'b0);
            gen_w = ref_next(gen_w);
        end
    endtask

    task automatic send_corrupt(input logic [31:0] mask);
        cyc(gen_w ^ mask, 1'b1, 1'b0);
        gen_w = ref_next(gen_w);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_err_pulse"}, 32'(err_pulse), 32'd0);
        check({tag, "_word_cnt"}, word_cnt, 32'd0);
        check({tag, "_err_word_cnt"}, err_word_cnt, 32'd0);
        check({tag, "_status"}, 32'(status), 32'd0);
        check({tag, "_in_search"}, 32'(dbg_state == SEARCH), 32'd1);
`ifdef LFSR_RX_CHECKER_BITERR_EN
        check({tag, "_bit_err_cnt"}, bit_err_cnt, 32'd0);
`endif
    endtask

    // Assert resetn between clock edges and check outputs drop at once
    task automatic mid_reset();
        @(posedge clk);
        have_pend = 0;
        #3;
        resetn   = 1'b0;
        rx_valid = 1'b0;
        clear    = 1'b0;
        exp_q.delete();
        #1;
        check_zero("async_rst");
        model_reset();
        #2;
        resetn = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int wait_cnt;
        n_checks = 0; n_fail = 0; have_pend = 0;
        resetn = 1'b0; rx_data = '0; rx_valid = 1'b0; clear = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #3;
        check_zero("in_reset");
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check_zero("after_reset");

        // Clean stream from seed 0x7FFFFFFF; lock follows the 64th match
        gen_w = 32'h7FFF_FFFF;
        send_clean(65);
        check("not_locked_after_63_matches", 32'(locked), 32'd0);
        send_clean(1);
        check("locked_after_64_matches", 32'(locked), 32'd1);
        send_clean(20);

        // Single bit flip while locked
        send_corrupt(32'd1 << $urandom_range(31, 0));
        send_clean(20);

        // Eight corrupted words force loss of lock, then relock
        for (int i = 0; i < UNLOCK_ERRS; i++) send_corrupt(32'h0000_0020);
        send_clean(1 + LOCK_WORDS + 10);

        // Clear coinciding with a counted word while err_word_cnt = 3
        cyc(gen_w, 1'b1, 1'b1);
        gen_w = ref_next(gen_w);
        for (int i = 0; i < 3; i++) begin
            send_corrupt(32'd1 << $urandom_range(31, 0));
            send_clean(3);
        end
        cyc(gen_w, 1'b1, 1'b1);
        gen_w = ref_next(gen_w);
        cyc('0, 1'b0, 1'b0);
        send_clean(5);

        // Mid-stream asynchronous reset
        mid_reset();

        // All-zero words never seed, then a fresh stream locks
        for (int i = 0; i < 100; i++) cyc('0, 1'b1, 1'b0);
        gen_w = $urandom() | 32'h1;
        send_clean(80);

        // rx_valid alternating on a clean stream
        mid_reset();
        gen_w = $urandom() | 32'h2;
        for (int i = 0; i < 150; i++) begin
            cyc(gen_w, 1'b1, 1'b0);
            gen_w = ref_next(gen_w);
            cyc($urandom(), 1'b0, 1'b0);
        end

        // Random traffic: gaps, bit errors, error bursts and clears
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = $urandom_range(199, 0);
            if (r == 0) begin
                for (int k = 0; k < $urandom_range(10, 6); k++) send_corrupt($urandom() | 32'h1);
            end else if (r < 12) begin
                send_corrupt($urandom() | 32'h100);
            end else if (r < 60) begin
                cyc($urandom(), 1'b0, ($urandom_range(15, 0) == 0));
            end else begin
                cyc(gen_w, 1'b1, ($urandom_range(63, 0) == 0));
                gen_w = ref_next(gen_w);
            end
        end

        // Drain: idle cycles cover the two-cycle bit counter latency
        cyc('0, 1'b0, 1'b0);
        cyc('0, 1'b0, 1'b0);
        @(posedge clk);
        exp_q.push_back(pend);
        have_pend = 0;
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 20) begin
            @(posedge clk);
            wait_cnt++;
        end
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
